// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot_product_4x4 datapath:
// FSM encodings, pipeline depth, product width and adder cells.
package dot_product_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PIPE_LAT = 2;
  localparam int PROD_W   = 8;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  // {carry, sum}
  function automatic logic [1:0] fa(
    input logic x,
    input logic y,
    input logic z
  );
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(
    input logic x,
    input logic y
  );
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/dot_product_4x4_wallace.sv
// Unsigned 4x4 Wallace-tree multiplier: two carry-save
// reduction levels followed by a final carry-propagate add.
module wallace_tree_4x4
  import dot_product_pkg::*;
(
  input  logic [3:0]        a_i,
  input  logic [3:0]        b_i,
  output logic [PROD_W-1:0] p_o
);

  logic [3:0][3:0] pp;
  logic [1:0] h1, f2, f3, f4, h5, f3b;
  logic [6:0] row_a;
  logic [6:0] row_b;
  logic [6:0] row_c;

  // pp[i][j] carries weight i+j
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = a_i & {4{b_i[i]}};
    end
  end

  assign h1  = ha(pp[0][1], pp[1][0]);
  assign f2  = fa(pp[0][2], pp[1][1], pp[2][0]);
  assign f3  = fa(pp[0][3], pp[1][2], pp[2][1]);
  assign f4  = fa(pp[1][3], pp[2][2], pp[3][1]);
  assign h5  = ha(pp[2][3], pp[3][2]);
  assign f3b = fa(f3[0], pp[3][0], f2[1]);

  assign row_a = {pp[3][3], h5[0], f4[0], f3b[0],
                  f2[0], h1[0], pp[0][0]};
  assign row_b = {h5[1], f4[1], f3[1], 1'b0,
                  h1[1], 2'b00};
  assign row_c = {2'b00, f3b[1], 4'b0000};

  assign p_o = PROD_W'(row_a) + PROD_W'(row_b)
             + PROD_W'(row_c);

endmodule

// File: rtl/dot_product_4x4.sv
// Streaming dot-product engine over wallace_tree_4x4 products.
// DOT_PRODUCT_SAT_EN: saturate the accumulator instead of wrapping.
module dot_product_4x4
  import dot_product_pkg::*;
#(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] Sum,
  output logic             ovf
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int FL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(PIPE_LAT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [FL_W-1:0]  flush_q;
  logic             in_ready_q;
  logic             out_valid_q;

  op_t              op_q;
  logic             op_vld_q;
  logic [PROD_W-1:0] prod_w;
  logic [PROD_W-1:0] prod_q;
  logic             prod_vld_q;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   add_w;
  logic             hs;

  assign hs = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      count_q     <= '0;
      flush_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= ST_ACCUM;
      count_q     <= '0;
      flush_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ACCUM: begin
          if (hs) begin
            if (count_q == CNT_LAST) begin
              count_q    <= '0;
              flush_q    <= '0;
              in_ready_q <= 1'b0;
              state_q    <= ST_DRAIN;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (flush_q == FL_LAST) begin
            flush_q     <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            flush_q <= flush_q + FL_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACCUM;
          end
        end
        default: begin
          state_q <= ST_ACCUM;
        end
      endcase
    end
  end

  wallace_tree_4x4 u_mul (
    .a_i (op_q.a),
    .b_i (op_q.b),
    .p_o (prod_w)
  );

  // The pipe is empty in DONE, so the result handshake never
  // collides with a product landing in the accumulator.
  always_comb begin
    add_w = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (out_valid_q && out_ready) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (prod_vld_q) begin
      acc_d = add_w[ACC_W-1:0];
      if (add_w[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef DOT_PRODUCT_SAT_EN
        acc_d = '1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      op_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (clr) begin
      op_q       <= '0;
      op_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      op_vld_q   <= hs;
      prod_vld_q <= op_vld_q;
      if (hs) begin
        op_q <= '{a: A, b: B};
      end
      if (op_vld_q) begin
        prod_q <= prod_w;
      end
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Sum       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dot_product_4x4.sv
// Randomized bench for dot_product_4x4 against a sum-of-products
// model; three configurations (16/12, 2/8, 1/12).
module tb_dot_product_4x4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic       clr [3];
  logic       iv [3];
  logic [3:0] av [3];
  logic [3:0] bv [3];
  logic       ordy [3];

  logic        rdy [3];
  logic        ov [3];
  logic        of [3];
  logic [11:0] sm [3];

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        of0, of1, of2;
  logic [11:0] sum0;
  logic [7:0]  sum1;
  logic [11:0] sum2;

  int vl [3] = '{16, 2, 1};
  int aw [3] = '{12, 8, 12};
  int tot [3];
  int t_last [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_product_4x4 #(.VEC_LEN(16), .ACC_W(12)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]),
    .in_valid(iv[0]), .in_ready(rdy0),
    .A(av[0]), .B(bv[0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .Sum(sum0), .ovf(of0)
  );

  dot_product_4x4 #(.VEC_LEN(2), .ACC_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]),
    .in_valid(iv[1]), .in_ready(rdy1),
    .A(av[1]), .B(bv[1]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .Sum(sum1), .ovf(of1)
  );

  dot_product_4x4 #(.VEC_LEN(1), .ACC_W(12)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]),
    .in_valid(iv[2]), .in_ready(rdy2),
    .A(av[2]), .B(bv[2]),
    .out_valid(ov2), .out_ready(ordy[2]),
    .Sum(sum2), .ovf(of2)
  );

  assign rdy[0] = rdy0;
  assign rdy[1] = rdy1;
  assign rdy[2] = rdy2;
  assign ov[0]  = ov0;
  assign ov[1]  = ov1;
  assign ov[2]  = ov2;
  assign of[0]  = of0;
  assign of[1]  = of1;
  assign of[2]  = of2;
  assign sm[0]  = sum0;
  assign sm[1]  = {4'd0, sum1};
  assign sm[2]  = sum2;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_sum(input int k);
    int lim;
    lim = 1 << aw[k];
`ifdef DOT_PRODUCT_SAT_EN
    return (tot[k] >= lim) ? lim - 1 : tot[k];
`else
    return tot[k] % lim;
`endif
  endfunction

  function automatic int exp_ovf(input int k);
    return (tot[k] >= (1 << aw[k])) ? 1 : 0;
  endfunction

  // idle cycles in ACCUM: block must stay ready, A/B are noise
  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      av[k] = 4'($urandom);
      bv[k] = 4'($urandom);
      chk("idle_rdy", 32'(rdy[k]), 1);
      @(negedge clk);
    end
  endtask

  task automatic feed(input int k, input int a, input int b);
    int n;
    n = 0;
    iv[k] = 1'b1;
    av[k] = 4'(a);
    bv[k] = 4'(b);
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("feed_rdy", 32'(rdy[k]), 1);
    t_last[k] = cyc;
    tot[k] += a * b;
    @(negedge clk);
    iv[k] = 1'b0;
    av[k] = 4'($urandom);
    bv[k] = 4'($urandom);
  endtask

  task automatic await_res(
    input int k,
    input int hold,
    input bit release_it
  );
    int n;
    n = 0;
    while (!ov[k] && n < 100) begin
      chk("drain_rdy", 32'(rdy[k]), 0);
      @(negedge clk);
      n++;
    end
    chk("out_valid", 32'(ov[k]), 1);
    chk("latency", 32'(cyc - t_last[k]), 3);
    chk("sum", 32'(sm[k]), 32'(exp_sum(k)));
    chk("ovf", 32'(of[k]), 32'(exp_ovf(k)));
    chk("done_rdy", 32'(rdy[k]), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov[k]), 1);
      chk("hold_sum", 32'(sm[k]), 32'(exp_sum(k)));
      chk("hold_rdy", 32'(rdy[k]), 0);
    end
    if (release_it) begin
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      tot[k] = 0;
      chk("rel_valid", 32'(ov[k]), 0);
      chk("rel_rdy", 32'(rdy[k]), 1);
      chk("rel_sum", 32'(sm[k]), 0);
      chk("rel_ovf", 32'(of[k]), 0);
    end
  endtask

  task automatic pulse_clr(input int k, input bit with_pair);
    clr[k] = 1'b1;
    iv[k]  = with_pair;
    av[k]  = 4'd9;
    bv[k]  = 4'd9;
    @(negedge clk);
    clr[k] = 1'b0;
    iv[k]  = 1'b0;
    tot[k] = 0;
    chk("clr_rdy", 32'(rdy[k]), 1);
    chk("clr_valid", 32'(ov[k]), 0);
    chk("clr_sum", 32'(sm[k]), 0);
    chk("clr_ovf", 32'(of[k]), 0);
  endtask

  task automatic rand_vec(input int k, input int max_gap);
    for (int i = 0; i < vl[k]; i++) begin
      idle(k, $urandom_range(0, max_gap));
      feed(k, $urandom_range(0, 15), $urandom_range(0, 15));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0;
      iv[k] = 1'b0;
      av[k] = '0;
      bv[k] = '0;
      ordy[k] = 1'b0;
      tot[k] = 0;
      t_last[k] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdy", 32'(rdy[k]), 1);
      chk("rst_valid", 32'(ov[k]), 0);
      chk("rst_sum", 32'(sm[k]), 0);
      chk("rst_ovf", 32'(of[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // full-scale operands, back to back
    for (int i = 0; i < 16; i++) feed(0, 15, 15);
    await_res(0, 0, 1'b1);

    // i*i with random bubbles
    for (int i = 0; i < 16; i++) begin
      idle(0, $urandom_range(0, 3));
      feed(0, i, i);
    end
    await_res(0, 0, 1'b1);

    // sink stalls, then next vector starts immediately
    rand_vec(0, 1);
    await_res(0, 5, 1'b1);
    for (int i = 0; i < 16; i++) feed(0, 1, 1);
    await_res(0, 0, 1'b1);

    // narrow accumulator overflow
    feed(1, 15, 15);
    feed(1, 15, 15);
    await_res(1, 0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      rand_vec(1, 2);
      await_res(1, $urandom_range(0, 2), 1'b1);
    end

    // abort mid-vector with a colliding pair
    for (int i = 0; i < 7; i++) feed(0, 7, 11);
    pulse_clr(0, 1'b1);
    for (int i = 0; i < 16; i++) feed(0, 2, 3);
    await_res(0, 0, 1'b1);

    // abort a held result
    feed(2, 7, 7);
    await_res(2, 2, 1'b0);
    pulse_clr(2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_vec(0, 2);
      await_res(0, $urandom_range(0, 3), 1'b1);
    end

    // async reset while draining
    for (int i = 0; i < 16; i++) feed(0, 9, 13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sm[0]), 0);
    chk("arst_rdy", 32'(rdy[0]), 1);
    chk("arst_valid", 32'(ov[0]), 0);
    chk("arst_ovf", 32'(of[0]), 0);
    for (int k = 0; k < 3; k++) tot[k] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    feed(2, 4, 5);
    await_res(2, 0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      rand_vec(2, 2);
      await_res(2, $urandom_range(0, 2), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
